// File: rtl/mem_dumper.sv
// ---------------------------------------------------------------------------
// mem_dumper
//   Walks a 32-bit data memory from word 0 to word DEPTH-1 after a rising
//   edge on dump_req, and presents every word (optionally dropping words that
//   read as zero) on a valid/ready output stream together with its byte
//   address. Each word costs one READ, one WAIT and at least one SEND cycle.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   dump_req     level request; a 0->1 transition seen in IDLE starts a dump
//   mem_rd_en    read strobe to the data memory (READ state only)
//   mem_rd_addr  word address of the read
//   mem_rd_data  read data, valid one cycle after mem_rd_en
//   out_valid    presented word is valid (SEND state only)
//   out_ready    sink accepts the presented word
//   out_addr     byte address of the presented word
//   out_data     presented word
//   busy         high whenever the walker is not in IDLE
//   done         one-cycle pulse when the dump completes
// ---------------------------------------------------------------------------
module mem_dumper #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 10,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_req,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W+1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] READ = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] SEND = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] count;
  logic              req_q;
  logic              start;
  logic              is_last;
  logic              drop_word;

  // A dump starts only on a fresh 0->1 of dump_req while idle; a level held
  // high from a previous dump never retriggers.
  assign start     = (state == IDLE) && dump_req && !req_q;
  assign is_last   = (count == LAST_WORD);
  assign drop_word = SKIP_ZERO && (mem_rd_data == 32'h0000_0000);

  // Walker state, word counter and the captured output word. The counter
  // stops at the terminal word instead of wrapping, so the terminal test in
  // WAIT/SEND is what ends the dump.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      req_q    <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      req_q <= dump_req;
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            state <= READ;
          end
        end
        READ: begin
          state <= WAIT;
        end
        WAIT: begin
          out_data <= mem_rd_data;
          out_addr <= {count, 2'b00};
          if (drop_word) begin
            if (is_last) begin
              state <= DONE;
            end else begin
              count <= count + 1'b1;
              state <= READ;
            end
          end else begin
            state <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (is_last) begin
              state <= DONE;
            end else begin
              count <= count + 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes are pure state decodes; the read address simply tracks the
  // counter, which is only meaningful while mem_rd_en is high.
  assign mem_rd_en   = (state == READ);
  assign mem_rd_addr = count;
  assign out_valid   = (state == SEND);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_mem_dumper.sv
// ---------------------------------------------------------------------------
// tb_mem_dumper
//   Two dumper instances (plain and zero-skipping, DEPTH=4) share clock,
//   reset, dump_req and out_ready. Each has its own memory model. A selector
//   picks which instance the scenario tasks observe; the expected word list
//   is computed directly from the memory contents.
// ---------------------------------------------------------------------------
module tb_mem_dumper;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic dump_req;
  logic out_ready;

  logic              a_rd_en, s_rd_en;
  logic [ADDR_W-1:0] a_rd_addr, s_rd_addr;
  logic [31:0]       a_rd_data = '0, s_rd_data = '0;
  logic              a_valid, s_valid;
  logic [ADDR_W+1:0] a_addr, s_addr;
  logic [31:0]       a_data, s_data;
  logic              a_busy, s_busy, a_done, s_done;

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_s [DEPTH];

  bit sel = 1'b0;

  logic              o_valid, o_rd_en, o_busy, o_done;
  logic [ADDR_W+1:0] o_addr;
  logic [31:0]       o_data;

  typedef struct {
    logic [ADDR_W+1:0] addr;
    logic [31:0]       data;
  } word_t;

  word_t exp_q[$];

  int pass_count  = 0;
  int check_count = 0;

  // Free-running clock
  always #5 clk = ~clk;

  // Synchronous read memories: data appears the cycle after the strobe
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
    if (s_rd_en) s_rd_data <= mem_s[s_rd_addr];
  end

  // Observed instance
  assign o_valid = sel ? s_valid : a_valid;
  assign o_rd_en = sel ? s_rd_en : a_rd_en;
  assign o_busy  = sel ? s_busy  : a_busy;
  assign o_done  = sel ? s_done  : a_done;
  assign o_addr  = sel ? s_addr  : a_addr;
  assign o_data  = sel ? s_data  : a_data;

  mem_dumper #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SKIP_ZERO(1'b0)) dut (
    .clk(clk), .rst(rst), .dump_req(dump_req),
    .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data),
    .out_valid(a_valid), .out_ready(out_ready),
    .out_addr(a_addr), .out_data(a_data),
    .busy(a_busy), .done(a_done)
  );

  mem_dumper #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SKIP_ZERO(1'b1)) dut_skip (
    .clk(clk), .rst(rst), .dump_req(dump_req),
    .mem_rd_en(s_rd_en), .mem_rd_addr(s_rd_addr), .mem_rd_data(s_rd_data),
    .out_valid(s_valid), .out_ready(out_ready),
    .out_addr(s_addr), .out_data(s_data),
    .busy(s_busy), .done(s_done)
  );

  // Advance one clock; sample/drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: every word in address order, minus zeros when skipping
  task automatic build_expect();
    logic [31:0] d;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      d = sel ? mem_s[i] : mem_a[i];
      if (!(sel && d == 32'h0))
        exp_q.push_back('{addr: (ADDR_W+2)'(i * 4), data: d});
    end
  endtask

  // Let both instances drain back to IDLE and release dump_req
  task automatic wait_idle();
    int k;
    out_ready = 1'b1;
    k = 0;
    while ((a_busy || s_busy) && k < 100) begin
      tick();
      k++;
    end
    check_count++;
    if (a_busy || s_busy)
      $display("[TB] FAIL idle_timeout a_busy=%0b s_busy=%0b required 0/0", a_busy, s_busy);
    else
      pass_count++;
    dump_req = 1'b0;
    tick();
    tick();
  endtask

  // One complete dump on the observed instance, checked against exp_q.
  // raise=0 means dump_req is already high and the next edge starts it.
  task automatic run_dump(input bit raise, input int ready_pct, input bit toggle,
                          input int stall_word, input string tag);
    int    cyc, words, dones, n_exp, first_valid, prev_hs, last_hs, stall_cnt;
    bit    finished, stall_prev;
    word_t e;
    logic [ADDR_W+1:0] held_addr;
    logic [31:0]       held_data;

    build_expect();
    n_exp       = exp_q.size();
    cyc         = 0;
    words       = 0;
    dones       = 0;
    first_valid = -1;
    prev_hs     = -1;
    last_hs     = -100;
    stall_cnt   = 0;
    finished    = 1'b0;
    stall_prev  = 1'b0;
    held_addr   = '0;
    held_data   = '0;
    if (raise) dump_req = 1'b1;

    while (!finished && cyc < 200) begin
      tick();
      cyc++;

      if (toggle) begin
        if (cyc == 4)  dump_req = 1'b0;
        if (cyc == 6)  dump_req = 1'b1;
        if (cyc == 8)  dump_req = 1'b0;
        if (cyc == 10) dump_req = 1'b1;
      end

      if (o_valid && words == stall_word && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = ($urandom_range(99) < ready_pct);
      end

      if (o_valid && first_valid < 0) first_valid = cyc;

      check_count++;
      if (o_rd_en && o_valid)
        $display("[TB] FAIL %s exclusive_strobes cyc=%0d rd_en=%0b valid=%0b required not both", tag, cyc, o_rd_en, o_valid);
      else
        pass_count++;

      if (stall_prev) begin
        check_count++;
        if (!(o_valid === 1'b1 && o_addr === held_addr && o_data === held_data && o_rd_en === 1'b0))
          $display("[TB] FAIL %s stall_hold cyc=%0d valid=%0b addr=%h data=%h rd_en=%0b required 1/%h/%h/0",
                   tag, cyc, o_valid, o_addr, o_data, o_rd_en, held_addr, held_data);
        else
          pass_count++;
      end

      if (o_done) begin
        dones++;
        finished = 1'b1;
        check_count++;
        if (exp_q.size() != 0)
          $display("[TB] FAIL %s early_done cyc=%0d remaining=%0d required 0", tag, cyc, exp_q.size());
        else
          pass_count++;
        if (!sel) begin
          check_count++;
          if (cyc != last_hs + 1)
            $display("[TB] FAIL %s done_timing cyc=%0d required %0d", tag, cyc, last_hs + 1);
          else
            pass_count++;
        end
      end

      stall_prev = 1'b0;
      if (o_valid) begin
        if (out_ready) begin
          check_count++;
          if (exp_q.size() == 0) begin
            $display("[TB] FAIL %s extra_word addr=%h data=%h required none", tag, o_addr, o_data);
          end else begin
            e = exp_q.pop_front();
            if (o_addr !== e.addr || o_data !== e.data)
              $display("[TB] FAIL %s word%0d addr=%h data=%h required %h/%h", tag, words, o_addr, o_data, e.addr, e.data);
            else
              pass_count++;
          end
          if (!sel && ready_pct == 100 && stall_word < 0 && prev_hs >= 0) begin
            check_count++;
            if (cyc - prev_hs != 3)
              $display("[TB] FAIL %s word_period got=%0d required 3", tag, cyc - prev_hs);
            else
              pass_count++;
          end
          prev_hs = cyc;
          last_hs = cyc;
          words++;
        end else begin
          stall_prev = 1'b1;
          held_addr  = o_addr;
          held_data  = o_data;
        end
      end
    end

    check_count++;
    if (!finished)
      $display("[TB] FAIL %s dump_timeout cycles=%0d required done", tag, cyc);
    else
      pass_count++;

    if (!sel) begin
      check_count++;
      if (first_valid != 3)
        $display("[TB] FAIL %s first_valid_latency got=%0d required 3", tag, first_valid);
      else
        pass_count++;
    end

    check_count++;
    if (words != n_exp)
      $display("[TB] FAIL %s word_count got=%0d required %0d", tag, words, n_exp);
    else
      pass_count++;

    // dump_req is still high here, so these cycles also prove no retrigger
    for (int k = 0; k < 3; k++) begin
      tick();
      if (o_done) dones++;
      check_count++;
      if (o_busy !== 1'b0)
        $display("[TB] FAIL %s restart busy=%0b required 0", tag, o_busy);
      else
        pass_count++;
    end

    check_count++;
    if (dones != 1)
      $display("[TB] FAIL %s done_pulses got=%0d required 1", tag, dones);
    else
      pass_count++;

    wait_idle();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    dump_req  = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check_count++;
    if ({a_rd_en, a_rd_addr, a_valid, a_addr, a_data, a_busy, a_done} !== '0)
      $display("[TB] FAIL reset_plain rd_en=%0b rd_addr=%h valid=%0b addr=%h data=%h busy=%0b done=%0b required all 0",
               a_rd_en, a_rd_addr, a_valid, a_addr, a_data, a_busy, a_done);
    else
      pass_count++;
    check_count++;
    if ({s_rd_en, s_rd_addr, s_valid, s_addr, s_data, s_busy, s_done} !== '0)
      $display("[TB] FAIL reset_skip rd_en=%0b rd_addr=%h valid=%0b addr=%h data=%h busy=%0b done=%0b required all 0",
               s_rd_en, s_rd_addr, s_valid, s_addr, s_data, s_busy, s_done);
    else
      pass_count++;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    check_count++;
    if (a_busy !== 1'b0 || s_busy !== 1'b0 || a_rd_en !== 1'b0)
      $display("[TB] FAIL idle_after_reset a_busy=%0b s_busy=%0b rd_en=%0b required 0", a_busy, s_busy, a_rd_en);
    else
      pass_count++;
  endtask

  task automatic test_basic_dump();
    sel = 1'b0;
    mem_a[0] = 32'h11; mem_a[1] = 32'h22; mem_a[2] = 32'h33; mem_a[3] = 32'h44;
    run_dump(1'b1, 100, 1'b0, -1, "basic");
  endtask

  task automatic test_stall();
    sel = 1'b0;
    mem_a[0] = 32'h11; mem_a[1] = 32'h22; mem_a[2] = 32'h33; mem_a[3] = 32'h44;
    run_dump(1'b1, 100, 1'b0, 1, "stall");
  endtask

  task automatic test_random_ready();
    sel = 1'b0;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < DEPTH; i++) mem_a[i] = $urandom;
      run_dump(1'b1, 50, 1'b0, -1, "random");
    end
  endtask

  task automatic test_skip_zero();
    sel = 1'b1;
    mem_s[0] = 32'h0; mem_s[1] = 32'h5; mem_s[2] = 32'h0; mem_s[3] = 32'h0;
    run_dump(1'b1, 100, 1'b0, -1, "skip_fixed");
    for (int i = 0; i < DEPTH; i++) mem_s[i] = 32'h0;
    run_dump(1'b1, 100, 1'b0, -1, "skip_all_zero");
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < DEPTH; i++) mem_s[i] = ($urandom_range(1) == 1) ? 32'h0 : $urandom;
      run_dump(1'b1, 60, 1'b0, -1, "skip_random");
    end
    sel = 1'b0;
  endtask

  task automatic test_toggle_req();
    sel = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_a[i] = $urandom;
    run_dump(1'b1, 100, 1'b1, -1, "toggle");
  endtask

  task automatic test_reset_mid_dump();
    int k;
    bit saw_done;
    sel = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_a[i] = $urandom;
    dump_req  = 1'b1;
    out_ready = 1'b1;
    saw_done  = 1'b0;
    k = 0;
    while (!(a_valid && a_addr == 4'h8) && k < 50) begin
      tick();
      if (a_done) saw_done = 1'b1;
      k++;
    end
    check_count++;
    if (!(a_valid === 1'b1 && a_addr === 4'h8) || saw_done)
      $display("[TB] FAIL reach_word2 valid=%0b addr=%h done_seen=%0b required 1/8/0", a_valid, a_addr, saw_done);
    else
      pass_count++;
    rst = 1'b1;
    tick();
    check_count++;
    if ({a_rd_en, a_rd_addr, a_valid, a_addr, a_data, a_busy, a_done} !== '0)
      $display("[TB] FAIL abort_outputs rd_en=%0b rd_addr=%h valid=%0b addr=%h data=%h busy=%0b done=%0b required all 0",
               a_rd_en, a_rd_addr, a_valid, a_addr, a_data, a_busy, a_done);
    else
      pass_count++;
    rst = 1'b0;
    run_dump(1'b0, 100, 1'b0, -1, "post_reset");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < DEPTH; i++) mem_a[i] = $urandom;
      run_dump(1'b1, 70, 1'b0, -1, "back_to_back");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '0;
      mem_s[i] = '0;
    end
    test_reset();
    test_basic_dump();
    test_stall();
    test_random_ready();
    test_skip_zero();
    test_toggle_req();
    test_reset_mid_dump();
    test_back_to_back();
    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/mem_dumper.md
MEM_DUMPER -- requirements
Module: mem_dumper

Interface
REQ-001: Parameter DEPTH, default 1024, number of 32-bit data-memory words walked per dump (power of two, >= 2).
REQ-002: Parameter ADDR_W, default 10, word-address width, log2(DEPTH).
REQ-003: Parameter SKIP_ZERO, default 0, when 1 words reading 0x00000000 are not emitted.
REQ-004: clk  input  1  sole clock, all state updates on rising edge.
REQ-005: rst  input  1  synchronous, active-high reset.
REQ-006: dump_req  input  1  level request from bench/CPU top; rising edge starts a dump.
REQ-007: mem_rd_en  output  1  read strobe to data memory.
REQ-008: mem_rd_addr  output  ADDR_W  word address of read.
REQ-009: mem_rd_data  input  32  read data, valid exactly one cycle after mem_rd_en.
REQ-010: out_valid  output  1  dump word available.
REQ-011: out_ready  input  1  sink accepts word.
REQ-012: out_addr  output  ADDR_W+2  byte address of presented word (word address << 2).
REQ-013: out_data  output  32  presented word.
REQ-014: busy  output  1  high in any state other than IDLE.
REQ-015: done  output  1  one-cycle pulse at dump completion.

Function
REQ-016: The block SHALL implement states IDLE, READ, WAIT, SEND, DONE.
REQ-017: Start SHALL be detected in IDLE when dump_req=1 and registered previous dump_req=0; IDLE->READ, word counter cleared to 0.
REQ-018: Rising edges of dump_req in any non-IDLE state SHALL be ignored (no restart, no queueing).
REQ-019: READ: mem_rd_en=1, mem_rd_addr=counter, for exactly one cycle; READ->WAIT.
REQ-020: WAIT: mem_rd_data SHALL be captured into out_data, out_addr={counter,2'b00}; WAIT->SEND, unless SKIP_ZERO=1 and data=0, then counter+1 and ->READ, or ->DONE if counter=DEPTH-1.
REQ-021: SEND: out_valid=1, out_data/out_addr SHALL hold stable until out_valid&&out_ready.
REQ-022: On handshake in SEND: counter=DEPTH-1 -> DONE; otherwise counter+1 -> READ.
REQ-023: Latency: first out_valid SHALL assert 3 cycles after the cycle the start edge is sampled; with out_ready held 1 each word costs 3 cycles.
REQ-024: Counter SHALL never wrap within a dump; DEPTH-1 is the terminal word.
REQ-025: DONE: done=1 for one cycle, DONE->IDLE unconditionally.
REQ-026: mem_rd_en SHALL be 0 in all states except READ; out_valid SHALL be 0 except in SEND.
REQ-027: out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028: With rst=1 at a clock edge: state=IDLE, counter=0, previous dump_req=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0.
REQ-029: Reset mid-dump SHALL abort immediately with no done pulse; dump_req held high through reset release SHALL start a new dump on the first non-reset edge.

Verification
REQ-030: DEPTH=4, mem={0x11,0x22,0x33,0x44}, out_ready=1, dump_req 0->1 -> words (0x0,0x11),(0x4,0x22),(0x8,0x33),(0xC,0x44) in order, out_valid 3 cycles after start edge, done one cycle after last handshake.
REQ-031: Same stimulus, out_ready low for 5 cycles during word 1 -> out_data=0x22, out_addr=0x4 stable throughout, no mem_rd_en while stalled.
REQ-032: SKIP_ZERO=1, mem={0x0,0x5,0x0,0x0} -> single word (0x4,0x5) emitted, then done pulse.
REQ-033: dump_req toggled 0->1->0->1 during a dump -> exactly DEPTH words, one done pulse, no restart.
REQ-034: rst asserted one cycle while in SEND of word 2 -> all outputs 0 next cycle, no done; dump_req held 1 -> fresh dump from address 0.
